// File: rtl/mshr_load_replay_pkg.sv
// Shared LSU/MSHR types for the secondary-load replay path.
//   - Request/response/branch-update structs used between the LSU, MSHR,
//     line buffer and dcache response arbiter.
//   - Replay queue entry and replay FSM state types.
//   - load_extend: byte-lane extraction plus sign/zero extension of a beat.
//   - br_update: applies one cycle of branch resolution to a queued entry.
package mshr_load_replay_pkg;

    localparam int dataBits = 64;
    localparam int BR_W     = 4;
    localparam int ROB_W    = 6;
    localparam int ADDR_W   = 40;
    localparam int LB_ID_W  = 2;

    typedef struct packed {
        logic [ROB_W-1:0] rob_idx;
        logic [BR_W-1:0]  br_mask;
        logic [1:0]       mem_size;   // 0=byte 1=half 2=word 3=double
        logic             mem_signed;
    } MicroOpST;

    typedef struct packed {
        MicroOpST          uop;
        logic [ADDR_W-1:0] addr;
        logic              is_hella;
    } BoomDCacheReqInternalST;

    typedef struct packed {
        logic [BR_W-1:0] resolve_mask;
        logic [BR_W-1:0] mispredict_mask;
    } BrUpdateInfoST;

    typedef struct packed {
        logic [LB_ID_W-1:0] id;
        logic [1:0]         offset;
    } LineBufferReadReqST;

    typedef struct packed {
        MicroOpST            uop;
        logic [dataBits-1:0] data;
        logic                is_hella;
    } BoomDCacheRespST;

    typedef struct packed {
        BoomDCacheReqInternalST req;
        logic                   killed;
    } ReplayEntryST;

    typedef enum logic [1:0] {IDLE, READ, DATA, RESP} ReplayStateE;

    function automatic logic [63:0] load_extend(input logic [dataBits-1:0] data,
                                                input logic [2:0]          addr_lo,
                                                input logic [1:0]          size,
                                                input logic                is_signed);
        logic [63:0] sh;
        logic [63:0] r;
        sh = data >> {addr_lo, 3'b000};
        case (size)
            2'd0:    r = is_signed ? {{56{sh[7]}},  sh[7:0]}  : {56'd0, sh[7:0]};
            2'd1:    r = is_signed ? {{48{sh[15]}}, sh[15:0]} : {48'd0, sh[15:0]};
            2'd2:    r = is_signed ? {{32{sh[31]}}, sh[31:0]} : {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    // Kill is evaluated on the mask before this cycle's resolve bits clear it.
    function automatic ReplayEntryST br_update(input ReplayEntryST e, input BrUpdateInfoST b);
        ReplayEntryST r;
        r = e;
        r.killed = e.killed | (|(e.req.uop.br_mask & b.mispredict_mask));
        r.req.uop.br_mask = e.req.uop.br_mask & ~b.resolve_mask;
        return r;
    endfunction

endpackage

// File: rtl/replay_queue.sv
// Circular replay queue of secondary loads.
//   clock/reset  : clock, synchronous active-high reset (drops all entries)
//   enq/enq_req  : push a request at tail (caller guarantees not full)
//   deq          : pop the head (caller guarantees not empty)
//   brupdate     : applied every cycle to all valid entries and the enqueuing uop
//   head_entry   : head with this cycle's branch update already folded in
//   count        : occupancy, 0..N
module replay_queue
    import mshr_load_replay_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq,
    input  BoomDCacheReqInternalST enq_req,
    input  logic                   deq,
    input  BrUpdateInfoST          brupdate,
    output ReplayEntryST           head_entry,
    output logic [$clog2(N):0]     count
);
    localparam int PW = $clog2(N);

    ReplayEntryST   ent_q [N];
    ReplayEntryST   ent_d [N];
    logic [N-1:0]   vld_q, vld_d;
    logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [PW:0]    count_q, count_d;
    ReplayEntryST   new_ent;

    always_comb begin
        new_ent        = '0;
        new_ent.req    = enq_req;
        new_ent.killed = 1'b0;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < N; i++)
            ent_d[i] = vld_q[i] ? br_update(ent_q[i], brupdate) : ent_q[i];
        if (deq) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        if (enq) begin
            ent_d[tail_q] = br_update(new_ent, brupdate);
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PW'(1);
        end
        count_d = count_q + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < N; i++) ent_q[i] <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < N; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign head_entry = vld_q[head_q] ? br_update(ent_q[head_q], brupdate) : '0;
    assign count      = count_q;

endmodule

// File: rtl/mshr_load_replay.sv
// MSHR secondary-load replay responder.
// Queues loads that missed on a line being refilled; once the refill is in
// the line buffer (start), replays each in order: read its beat, extract and
// extend the bytes, and return a response to the LSU.
//   enq_*        : secondary load intake (only while IDLE and not full)
//   lb_id/start  : owning line-buffer id, refill-complete pulse
//   brupdate     : branch resolve/mispredict masks
//   lb_read_*    : line-buffer beat read (data arrives the cycle after accept)
//   resp_*       : load response to the dcache response arbiter
//   replay_done  : pulse when the queue has drained after start
//   busy         : FSM not IDLE
module mshr_load_replay
    import mshr_load_replay_pkg::*;
#(
    parameter int N_REPLAY  = 4,
    parameter int DATA_BITS = dataBits
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  BoomDCacheReqInternalST enq_req,
    input  logic [LB_ID_W-1:0]     lb_id,
    input  logic                   start,
    input  BrUpdateInfoST          brupdate,
    output logic                   lb_read_valid,
    input  logic                   lb_read_ready,
    output LineBufferReadReqST     lb_read_req,
    input  logic [DATA_BITS-1:0]   lb_read_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output BoomDCacheRespST        resp,
    output logic                   replay_done,
    output logic                   busy
);
    localparam int CW = $clog2(N_REPLAY) + 1;

    ReplayStateE    state_q, state_d;
    logic [63:0]    data_q, data_d;
    logic           done_q, done_d;
    logic           deq, enq_fire, start_done;
    logic [CW-1:0]  count, count_m1;
    ReplayEntryST   head;

    assign enq_ready = (state_q == IDLE) && (count != CW'(N_REPLAY));
    assign enq_fire  = enq_valid & enq_ready;
    assign count_m1  = count - CW'(1);

    replay_queue #(.N(N_REPLAY)) u_replay_queue (
        .clock      (clock),
        .reset      (reset),
        .enq        (enq_fire),
        .enq_req    (enq_req),
        .deq        (deq),
        .brupdate   (brupdate),
        .head_entry (head),
        .count      (count)
    );

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        done_d        = 1'b0;
        deq           = 1'b0;
        start_done    = 1'b0;
        lb_read_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state_q)
            IDLE: begin
                // An entry enqueued alongside start is part of this replay.
                if (start) begin
                    if (count != '0 || enq_fire) state_d = READ;
                    else                         start_done = 1'b1;
                end
            end
            READ: begin
                if (head.killed) begin
                    deq = 1'b1;
                    if (count_m1 != '0) state_d = READ;
                    else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    lb_read_valid = 1'b1;
                    if (lb_read_ready) state_d = DATA;
                end
            end
            DATA: begin
                data_d  = load_extend(lb_read_data, head.req.addr[2:0],
                                      head.req.uop.mem_size, head.req.uop.mem_signed);
                state_d = RESP;
            end
            RESP: begin
                resp_valid = !head.killed;
                if ((resp_valid && resp_ready) || head.killed) begin
                    deq = 1'b1;
                    if (count_m1 != '0) state_d = READ;
                    else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Drain completion is registered so it lands the cycle after the last
    // dequeue; an empty start answers immediately.
    assign replay_done = done_q | start_done;
    assign busy        = (state_q != IDLE);

    // Request/response payloads are zeroed when not valid so idle outputs are 0.
    always_comb begin
        lb_read_req = '0;
        resp        = '0;
        if (lb_read_valid) begin
            lb_read_req.id     = lb_id;
            lb_read_req.offset = head.req.addr[4:3];
        end
        if (resp_valid) begin
            resp.uop      = head.req.uop;
            resp.data     = data_q;
            resp.is_hella = head.req.is_hella;
        end
    end

endmodule
